// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int DEF_DATAWIDTH = 32;
   localparam int DEF_REGCOUNT  = 32;
   localparam int DEF_ADDRW     = 5;

   // Register 0 is hardwired zero; writes to it are accepted and discarded.
   localparam int ZERO_REG = 0;

   // Requester identities, also used as bit positions in req/gnt vectors.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter. The pointer remembers the winner of the
// last contended grant and only moves when both requesters were valid.
module rr_arbiter2
   import regfile_wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   req_e last_q;
   req_e last_d;

   // Grant selection and pointer next-state.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      gnt    = '0;
      last_d = last_q;
      case (req)
         2'b11: begin
            if (last_q == REQ_LSU) begin
               gnt[REQ_ALU] = 1'b1;
               last_d       = REQ_ALU;
            end else begin
               gnt[REQ_LSU] = 1'b1;
               last_d       = REQ_LSU;
            end
         end
         2'b01:   gnt[REQ_ALU] = 1'b1;
         2'b10:   gnt[REQ_LSU] = 1'b1;
         default: ;
      endcase
   end

   // Pointer register; reset as if the LSU won last so the ALU wins first.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (!rst_n) last_q <= REQ_LSU;
      else        last_q <= last_d;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and LSU writebacks, registers
// the winning write, and tracks per-register busy bits for issue hazards.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int REGCOUNT  = DEF_REGCOUNT,
   parameter int ADDRW     = DEF_ADDRW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid,
   input  logic [ADDRW-1:0]     alu_rd,
   input  logic [DATAWIDTH-1:0] alu_data,
   output logic                 alu_ready,
   input  logic                 lsu_valid,
   input  logic [ADDRW-1:0]     lsu_rd,
   input  logic [DATAWIDTH-1:0] lsu_data,
   output logic                 lsu_ready,
   input  logic                 iss_valid,
   input  logic [ADDRW-1:0]     iss_rs1,
   input  logic [ADDRW-1:0]     iss_rs2,
   input  logic [ADDRW-1:0]     iss_rd,
   output logic                 iss_hazard,
   output logic                 write,
   output logic [ADDRW-1:0]     writeReg,
   output logic [DATAWIDTH-1:0] writeData
);

   // Busy vectors span the full index space; slots >= REGCOUNT never set.
   localparam int NSLOT = 2 ** ADDRW;

   logic [1:0]           req;
   logic [1:0]           gnt;
   logic [ADDRW-1:0]     sel_rd;
   logic [DATAWIDTH-1:0] sel_data;

   logic                 write_q,      write_d;
   logic [ADDRW-1:0]     write_reg_q,  write_reg_d;
   logic [DATAWIDTH-1:0] write_data_q, write_data_d;
   logic [NSLOT-1:0]     busy_q,       busy_d;
   logic [NSLOT-1:0]     eff_busy;

   assign req[REQ_ALU] = alu_valid;
   assign req[REQ_LSU] = lsu_valid;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .gnt   (gnt)
   );

   assign alu_ready = gnt[REQ_ALU];
   assign lsu_ready = gnt[REQ_LSU];

   assign write     = write_q;
   assign writeReg  = write_reg_q;
   assign writeData = write_data_q;

   // Mux the granted request into the next write; x0 writes are swallowed.
   always_comb begin
      sel_rd       = gnt[REQ_LSU] ? lsu_rd   : alu_rd;
      sel_data     = gnt[REQ_LSU] ? lsu_data : alu_data;
      write_d      = (|gnt) && (sel_rd != ADDRW'(ZERO_REG));
      write_reg_d  = write_d ? sel_rd   : write_reg_q;
      write_data_d = write_d ? sel_data : write_data_q;
   end

   // Effective busy: a register being written this cycle is forwarded by
   // the regfile, so it no longer blocks issue.
   always_comb begin
      for (int i = 0; i < NSLOT; i++) begin
         eff_busy[i] = busy_q[i] && (i != ZERO_REG)
                       && !(write_q && (write_reg_q == ADDRW'(i)));
      end
      iss_hazard = iss_valid
                   && (eff_busy[iss_rs1] || eff_busy[iss_rs2] || eff_busy[iss_rd]);
   end

   // Scoreboard update: clear on the completing write, then set on issue.
   always_comb begin
      busy_d = busy_q;
      if (write_q && (int'(write_reg_q) < REGCOUNT))
         busy_d[write_reg_q] = 1'b0;
      if (iss_valid && !iss_hazard && (iss_rd != ADDRW'(ZERO_REG))
          && (int'(iss_rd) < REGCOUNT))
         busy_d[iss_rd] = 1'b1;
   end

   // Output register and scoreboard state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         write_q      <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset
         // here; stale busy bits after reset would stall issue forever.
         busy_q       <= '0;
      end else begin
         write_q      <= write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration, write latency,
// x0 suppression, scoreboard hazards and reset behaviour.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, lsu_valid, iss_valid;
   logic [4:0]  alu_rd, lsu_rd, iss_rs1, iss_rs2, iss_rd;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, iss_hazard, write;
   logic [4:0]  writeReg;
   logic [31:0] writeData;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .lsu_valid  (lsu_valid),
      .lsu_rd     (lsu_rd),
      .lsu_data   (lsu_data),
      .lsu_ready  (lsu_ready),
      .iss_valid  (iss_valid),
      .iss_rs1    (iss_rs1),
      .iss_rs2    (iss_rs2),
      .iss_rd     (iss_rd),
      .iss_hazard (iss_hazard),
      .write      (write),
      .writeReg   (writeReg),
      .writeData  (writeData)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
   endtask

   initial begin
      logic [31:0] a_data, l_data;
      logic        exp_alu;

      rst_n = 1'b0;
      idle();
      tick(); tick();
      check("rst_write",     {31'd0, write}, 32'd0);
      check("rst_writeReg",  {27'd0, writeReg}, 32'd0);
      check("rst_writeData", writeData, 32'd0);
      check("rst_no_ready",  {30'd0, alu_ready, lsu_ready}, 32'd0);
      rst_n = 1'b1;

      // Single ALU writeback: ready same cycle, write one cycle later.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; #1;
      check("t1_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("t1_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      tick();
      alu_valid = 1'b0;
      check("t1_write",     {31'd0, write}, 32'd1);
      check("t1_writeReg",  {27'd0, writeReg}, 32'd5);
      check("t1_writeData", writeData, 32'h1234);
      tick();
      check("t1_write_off", {31'd0, write}, 32'd0);

      // Continuous contention: grants alternate, waiting side holds data.
      a_data = 32'hA000_0000;
      l_data = 32'hB000_0000;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd3; alu_data = a_data;
         lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = l_data;
         exp_alu = (i % 2 == 0);
         #1;
         check($sformatf("t2_alu_ready_%0d", i), {31'd0, alu_ready}, {31'd0, exp_alu});
         check($sformatf("t2_lsu_ready_%0d", i), {31'd0, lsu_ready}, {31'd0, !exp_alu});
         tick();
         check($sformatf("t2_write_%0d", i), {31'd0, write}, 32'd1);
         check($sformatf("t2_reg_%0d", i), {27'd0, writeReg}, exp_alu ? 32'd3 : 32'd4);
         check($sformatf("t2_data_%0d", i), writeData, exp_alu ? a_data : l_data);
         if (exp_alu) a_data = a_data + 32'd1;
         else         l_data = l_data + 32'd1;
      end
      idle();

      // RAW hazard on a busy register, cleared by the same-cycle write.
      issue(5'd0, 5'd0, 5'd7); #1;
      check("t3_issue7_ok", {31'd0, iss_hazard}, 32'd0);
      tick();
      issue(5'd7, 5'd0, 5'd8); #1;
      check("t3_raw_rs1", {31'd0, iss_hazard}, 32'd1);
      tick();
      iss_valid = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'd77; #1;
      check("t3_lsu_ready", {31'd0, lsu_ready}, 32'd1);
      tick();
      lsu_valid = 1'b0;
      issue(5'd0, 5'd7, 5'd10); #1;
      check("t3_wr7_write", {31'd0, write}, 32'd1);
      check("t3_wr7_reg",   {27'd0, writeReg}, 32'd7);
      check("t3_bypass_rs2", {31'd0, iss_hazard}, 32'd0);
      tick();
      issue(5'd7, 5'd0, 5'd0); #1;
      check("t3_r7_cleared", {31'd0, iss_hazard}, 32'd0);
      issue(5'd10, 5'd0, 5'd0); #1;
      check("t3_r10_busy", {31'd0, iss_hazard}, 32'd1);
      issue(5'd0, 5'd0, 5'd8); #1;
      check("t3_stalled_no_set", {31'd0, iss_hazard}, 32'd0);
      issue(5'd10, 5'd0, 5'd0); iss_valid = 1'b0; #1;
      check("t3_no_valid", {31'd0, iss_hazard}, 32'd0);

      // x0 writeback accepted but suppressed; x0 sources never hazard.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF; #1;
      check("t4_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0;
      check("t4_no_write", {31'd0, write}, 32'd0);
      issue(5'd0, 5'd0, 5'd0); #1;
      check("t4_x0_hazard", {31'd0, iss_hazard}, 32'd0);
      tick();
      iss_valid = 1'b0;

      // Set wins over clear for the same register at the same edge.
      issue(5'd0, 5'd0, 5'd9); #1;
      check("t5_issue9", {31'd0, iss_hazard}, 32'd0);
      tick();
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'd99;
      tick();
      alu_valid = 1'b0;
      issue(5'd0, 5'd0, 5'd9); #1;
      check("t5_wr9_reg", {27'd0, writeReg}, 32'd9);
      check("t5_reissue9", {31'd0, iss_hazard}, 32'd0);
      tick();
      issue(5'd9, 5'd0, 5'd11); #1;
      check("t5_set_wins", {31'd0, iss_hazard}, 32'd1);
      iss_valid = 1'b0;

      // Busy bits, a pending write and a moved pointer all cleared by reset.
      issue(5'd0, 5'd0, 5'd2); tick();
      issue(5'd0, 5'd0, 5'd6); tick();
      issue(5'd2, 5'd6, 5'd0); #1;
      check("t6_busy_2_6", {31'd0, iss_hazard}, 32'd1);
      iss_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
      lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hD0; #1;
      check("t6_pre_alu_wins", {31'd0, alu_ready}, 32'd1);
      tick();
      alu_data = 32'hC1;
      check("t6_pending_write", {31'd0, write}, 32'd1);
      rst_n = 1'b0;
      issue(5'd0, 5'd0, 5'd13);
      tick();
      rst_n = 1'b1;
      iss_valid = 1'b0; #1;
      check("t6_rst_write",     {31'd0, write}, 32'd0);
      check("t6_rst_writeReg",  {27'd0, writeReg}, 32'd0);
      check("t6_rst_writeData", writeData, 32'd0);
      check("t6_post_alu_ready", {31'd0, alu_ready}, 32'd1);
      check("t6_post_lsu_ready", {31'd0, lsu_ready}, 32'd0);
      tick();
      check("t6_post_reg",  {27'd0, writeReg}, 32'd12);
      check("t6_post_data", writeData, 32'hC1);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      issue(5'd2, 5'd6, 5'd13); #1;
      check("t6_busy_cleared", {31'd0, iss_hazard}, 32'd0);
      issue(5'd9, 5'd10, 5'd13); #1;
      check("t6_busy_9_10_cleared", {31'd0, iss_hazard}, 32'd0);
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
